// File: rtl/sevenseg_scan.sv
// Time-multiplexed 4-digit common-anode seven-segment driver with per-frame input snapshot and anode dead-time.
// Optional leading-zero blanking is compiled in when SEVSEG_LZB_EN is defined.
module sevenseg_scan #(
    parameter int REFRESH_DIV = 100000,
    parameter int DEAD_CYC    = 1000
) (
    input  logic        mclk,
    input  logic        rst_n,
    input  logic [15:0] digits,
    input  logic [3:0]  dp_mask,
    input  logic        blank,
    output logic [3:0]  an,
    output logic [7:0]  seg,
    output logic        frame_start
);

    localparam int              CNT_W   = $clog2(REFRESH_DIV);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_DIV - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       idx_q, idx_d;
    logic             run_q, run_d;
    logic [15:0]      snap_digits_q, snap_digits_d;
    logic [3:0]       snap_dp_q, snap_dp_d;
    logic [3:0]       an_q, an_d;
    logic [7:0]       seg_q, seg_d;
    logic             frame_start_q, frame_start_d;

    logic             tick;
    logic             suppress;
    logic             dead_ok;
    logic [3:0]       nib_sel;
    logic             dp_sel;

    // Returns the active-low g..a pattern; the dp bit is added by the caller.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] pat;
        case (nib)
            4'h0: pat = 7'h40;
            4'h1: pat = 7'h79;
            4'h2: pat = 7'h24;
            4'h3: pat = 7'h30;
            4'h4: pat = 7'h19;
            4'h5: pat = 7'h12;
            4'h6: pat = 7'h02;
            4'h7: pat = 7'h78;
            4'h8: pat = 7'h00;
            4'h9: pat = 7'h10;
            4'hA: pat = 7'h08;
            4'hB: pat = 7'h03;
            4'hC: pat = 7'h46;
            4'hD: pat = 7'h21;
            4'hE: pat = 7'h06;
            default: pat = 7'h0E;
        endcase
        return pat;
    endfunction

    assign tick = (cnt_q == CNT_MAX);

    // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        cnt_d         = cnt_q + CNT_W'(1);
        idx_d         = idx_q;
        run_d         = run_q;
        snap_digits_d = snap_digits_q;
        snap_dp_d     = snap_dp_q;
        frame_start_d = 1'b0;
        if (tick) begin
            cnt_d = '0;
            idx_d = idx_q + 2'd1;
            run_d = 1'b1;
            if (idx_q == 2'd3) begin
                snap_digits_d = digits;
                snap_dp_d     = dp_mask;
                frame_start_d = 1'b1;
            end
        end
    end

`ifdef SEVSEG_LZB_EN
    // A digit is a leading zero when it and every more-significant nibble are zero.
    // Only slots 1..3 qualify, and those always read a settled snapshot.
    always_comb begin
        case (idx_d)
            2'd3:    suppress = (snap_digits_q[15:12] == 4'h0);
            2'd2:    suppress = (snap_digits_q[15:8]  == 8'h00);
            2'd1:    suppress = (snap_digits_q[15:4]  == 12'h000);
            default: suppress = 1'b0;
        endcase
    end
`else
    assign suppress = 1'b0;
`endif

    if (DEAD_CYC == 0) begin : g_no_dead
        assign dead_ok = 1'b1;
    end else begin : g_dead
        assign dead_ok = (cnt_d >= CNT_W'(DEAD_CYC));
    end

    always_comb begin
        // Slot 0 is encoded on the snapshot edge itself, so it must read the live inputs.
        if (idx_q == 2'd3) begin
            nib_sel = digits[3:0];
            dp_sel  = dp_mask[0];
        end else begin
            nib_sel = snap_digits_q[{idx_d, 2'b00} +: 4];
            dp_sel  = snap_dp_q[idx_d];
        end

        seg_d = seg_q;
        if (tick) begin
            seg_d = {~(dp_sel & ~suppress), hex_to_seg(nib_sel)};
        end

        an_d = 4'b1111;
        if (run_d && dead_ok && !blank && !suppress) begin
            an_d = ~(4'b0001 << idx_d);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    // NOTE: the snapshot is reset too, so the first frame never displays undefined data.
    always_ff @(posedge mclk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q         <= '0;
            idx_q         <= 2'd3;
            run_q         <= 1'b0;
            snap_digits_q <= '0;
            snap_dp_q     <= '0;
            an_q          <= 4'b1111;
            seg_q         <= 8'hFF;
            frame_start_q <= 1'b0;
        end else begin
            cnt_q         <= cnt_d;
            idx_q         <= idx_d;
            run_q         <= run_d;
            snap_digits_q <= snap_digits_d;
            snap_dp_q     <= snap_dp_d;
            an_q          <= an_d;
            seg_q         <= seg_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign an          = an_q;
    assign seg         = seg_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_sevenseg_scan.sv
// Self-checking bench for sevenseg_scan with REFRESH_DIV=8, DEAD_CYC=2.
// Table-driven frame vectors through a scoreboard queue, plus startup, torn-value, blank and reset sequences.
module tb_sevenseg_scan;

    localparam int RDIV  = 8;
    localparam int DEAD  = 2;
    localparam int FRAME = 4 * RDIV;

    logic        mclk;
    logic        rst_n;
    logic [15:0] digits;
    logic [3:0]  dp_mask;
    logic        blank;
    logic [3:0]  an;
    logic [7:0]  seg;
    logic        frame_start;

    sevenseg_scan #(.REFRESH_DIV(RDIV), .DEAD_CYC(DEAD)) dut (
        .mclk        (mclk),
        .rst_n       (rst_n),
        .digits      (digits),
        .dp_mask     (dp_mask),
        .blank       (blank),
        .an          (an),
        .seg         (seg),
        .frame_start (frame_start)
    );

    initial mclk = 1'b0;
    always #5 mclk = ~mclk;

    typedef struct {
        logic [15:0]     digits;
        logic [3:0]      dp;
        logic [3:0][7:0] seg;   // seg[i] = expected pattern in slot i
    } vec_t;

    typedef struct packed {
        logic [1:0] slot;
        logic [7:0] seg;
        logic [3:0] an;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[5];
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge mclk);
    endtask

    // Expected anode pattern mid-slot for a given slot and displayed value.
    function automatic logic [3:0] exp_an(input int slot, input logic [15:0] d);
`ifdef SEVSEG_LZB_EN
        if (slot > 0 && (d >> (4 * slot)) == 16'h0) return 4'b1111;
`endif
        return ~(4'b0001 << slot);
    endfunction

    task automatic push_frame(input logic [15:0] d, input logic [3:0][7:0] s, input int first_slot);
        exp_t e;
        for (int i = first_slot; i < 4; i++) begin
            e.slot = 2'(i);
            e.seg  = s[i];
            e.an   = exp_an(i, d);
            sb.push_back(e);
        end
    endtask

    task automatic check_pop();
        exp_t e;
        if (sb.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL sb_underflow: got empty queue, expected an entry");
        end else begin
            e = sb.pop_front();
            check($sformatf("seg_slot%0d", e.slot), seg, e.seg);
            check($sformatf("an_slot%0d", e.slot), an, e.an);
        end
    endtask

    // Leaves the bench at the negedge where frame_start is high; cycles = negedges waited.
    task automatic wait_fs(input int budget, output int cycles);
        bit found;
        found  = 1'b0;
        cycles = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge mclk);
            cycles++;
            if (frame_start) begin
                found = 1'b1;
                break;
            end
        end
        check("frame_start_seen", found, 1'b1);
    endtask

    // Called right after rst_n is released at a negedge.
    task automatic check_startup(input logic [7:0] exp_seg0);
        for (int e = 1; e < RDIV; e++) begin
            step(1);
            check("pre_tick_an", an, 4'b1111);
            check("pre_tick_seg", seg, 8'hFF);
            check("pre_tick_fs", frame_start, 1'b0);
        end
        step(1);
        check("first_tick_fs", frame_start, 1'b1);
        check("first_tick_an", an, 4'b1111);
        check("first_tick_seg", seg, exp_seg0);
    endtask

    initial begin
        int cyc;
        logic [3:0] ea;

        vecs[0] = '{16'h1234, 4'b0100, {8'hF9, 8'h24, 8'hB0, 8'h99}};
        vecs[1] = '{16'hABCD, 4'b0000, {8'h88, 8'h83, 8'hC6, 8'hA1}};
        vecs[2] = '{16'hEF89, 4'b1001, {8'h06, 8'h8E, 8'h80, 8'h10}};
        vecs[3] = '{16'h5670, 4'b1111, {8'h12, 8'h02, 8'h78, 8'h40}};
        vecs[4] = '{16'h0050, 4'b0000, {8'hC0, 8'hC0, 8'h92, 8'hC0}};

        rst_n   = 1'b0;
        digits  = 16'h1234;
        dp_mask = 4'b0000;
        blank   = 1'b0;
        step(1);
        check("reset_an", an, 4'b1111);
        check("reset_seg", seg, 8'hFF);
        check("reset_fs", frame_start, 1'b0);
        step(2);
        rst_n = 1'b1;

        // Startup and the first full frame of anode timing.
        check_startup(8'h99);
        for (int k = 1; k <= FRAME; k++) begin
            step(1);
            ea = ((k % RDIV) >= DEAD) ? exp_an((k / RDIV) % 4, digits) : 4'b1111;
            check($sformatf("an_seq_k%0d", k), an, ea);
            check($sformatf("fs_seq_k%0d", k), frame_start, (k == FRAME));
        end

        // Table vectors: one frame per record, checked mid-slot.
        foreach (vecs[v]) begin
            digits  = vecs[v].digits;
            dp_mask = vecs[v].dp;
            push_frame(vecs[v].digits, vecs[v].seg, 0);
            wait_fs(FRAME + 8, cyc);
            step(RDIV / 2);
            for (int s = 0; s < 4; s++) begin
                check_pop();
                if (s < 3) step(RDIV);
            end
        end

        // Inputs change while slot 1 is showing: rest of the frame keeps the old snapshot.
        digits  = 16'h0999;
        dp_mask = 4'b0000;
        wait_fs(FRAME + 8, cyc);
        step(RDIV + 2);
        digits = 16'h1000;
        push_frame(16'h0999, {8'hC0, 8'h90, 8'h90, 8'h90}, 1);
        push_frame(16'h1000, {8'hF9, 8'hC0, 8'hC0, 8'hC0}, 0);
        step(2);
        for (int j = 0; j < 7; j++) begin
            check_pop();
            if (j == 2) begin
                step(RDIV / 2);
                check("torn_next_fs", frame_start, 1'b1);
                step(RDIV / 2);
            end else if (j < 6) begin
                step(RDIV);
            end
        end

        // Blank for five cycles inside slot 0; frame period must not move.
        wait_fs(FRAME + 8, cyc);
        step(1);
        blank = 1'b1;
        for (int k = 2; k <= 6; k++) begin
            step(1);
            check($sformatf("blank_an_k%0d", k), an, 4'b1111);
        end
        blank = 1'b0;
        step(1);
        check("blank_release_an", an, exp_an(0, digits));
        step(3);
        check("blank_slot1_an", an, exp_an(1, digits));
        wait_fs(FRAME + 8, cyc);
        check("blank_frame_period", cyc, FRAME - 10);

        // Asynchronous reset in slot 2, then restart from a clean first tick.
        step(2 * RDIV + RDIV / 2);
        check("pre_reset_an", an, exp_an(2, digits));
        rst_n = 1'b0;
        #1;
        check("async_reset_an", an, 4'b1111);
        check("async_reset_seg", seg, 8'hFF);
        check("async_reset_fs", frame_start, 1'b0);
        step(2);
        rst_n = 1'b1;
        check_startup(8'hC0);
        step(DEAD);
        check("post_reset_slot0_an", an, 4'b1110);

        check("sb_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/sevenseg_scan.md
# sevenseg_scan

- Time-multiplexed driver for the 4-digit common-anode seven-segment display.
- Sits directly downstream of the stopwatch digit counters:
  - Consumes four 4-bit digit values and a decimal-point mask.
  - Produces the active-low anode and segment buses that go to the board pins.
- Snapshots all inputs once per frame, so a carry in the counters never shows a torn value.
- Inserts an anode dead-time at each digit change to suppress ghosting.

## Interface
- REFRESH_DIV, 100000: mclk cycles per digit slot (1 ms at 100 MHz); legal range 2..2^27-1.
- DEAD_CYC, 1000: cycles at the start of each slot with all anodes off; must be < REFRESH_DIV.
- mclk  in  1  system clock; all state changes on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- digits  in  16  {d3,d2,d1,d0}; d0 = rightmost digit; values 0-15 are encoded as hex 0-F.
- dp_mask  in  4  decimal point lit for digit i when dp_mask[i]=1.
- blank  in  1  forces all anodes off while high.
- an  out  4  active-low anode enables, bit i = digit i.
- seg  out  8  active-low cathodes; seg[7] = dp, seg[6:0] = g..a.
- frame_start  out  1  one-cycle pulse on the cycle the snapshot is taken.

## Operation
- Prescaler `cnt` counts 0..REFRESH_DIV-1; `tick` is asserted when cnt == REFRESH_DIV-1.
- On `tick`, cnt wraps to 0 and the slot index `idx` advances 0→1→2→3→0.
- Reset values:
  - cnt=0, idx=3, snapshot=0.
  - an=4'b1111, seg=8'hFF, frame_start=0.
- Frame boundary (tick with idx==3):
  - snap_digits <= digits, snap_dp <= dp_mask, frame_start <= 1 for one cycle.
  - seg for slot 0 is encoded from the live `digits`/`dp_mask`, not the stale snapshot.
- Other slots encode from the snapshot only. Mid-frame input changes become visible at the next frame.
- seg is registered and loaded on the tick edge: seg[6:0] = hex pattern for the nibble, seg[7] = ~dp bit.
  - Hex patterns: 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90, A=88, b=83, C=C6, d=A1, E=86, F=8E.
- `an` is registered and asserts only bit idx (low) when all of the following hold:
  - cnt >= DEAD_CYC;
  - blank == 0;
  - the digit is not suppressed (see Configuration).
  - Otherwise an = 4'b1111.
- `blank` is sampled every cycle and does not stall cnt or idx.
- Asserting rst_n low mid-frame immediately forces the reset values. Scanning resumes with the first tick REFRESH_DIV cycles after release.

## Timing
- Slot length is exactly REFRESH_DIV cycles; frame length is 4*REFRESH_DIV.
- First frame_start occurs on the cycle after edge number REFRESH_DIV following rst_n release, i.e. the first tick (idx 3→0).
- Within a slot, seg is valid from the tick edge. `an` goes low on the edge where cnt reaches DEAD_CYC, and back high on the next tick edge.
- blank 0→1: an = 1111 on the next edge. blank 1→0: the digit's anode reasserts on the next edge, provided cnt >= DEAD_CYC.
- DEAD_CYC = 0: the anode asserts on the same edge as the tick.
- Input-to-pin latency is at most 4*REFRESH_DIV + 1 cycles.

## Configuration
- SEVSEG_LZB_EN defined (leading-zero blanking):
  - Digit i ∈ {3,2,1} is suppressed when its snapshot nibble and every higher nibble are 0.
  - A suppressed digit keeps its anode high and its dp off.
  - Digit 0 is never suppressed.
  - Evaluation uses the same snapshot the slot displays (live values for slot 0's own nibble only).
- SEVSEG_LZB_EN undefined: no suppression logic is generated; all four digits display, including leading zeros.

## Test plan
- Reset release, REFRESH_DIV=8, DEAD_CYC=2 → an=1111, seg=FF until the first tick. Then:
  - frame_start pulses once.
  - an sequence: 1111 ×2 cycles, 1110 ×6, 1111 ×2, 1101 ×6, …
  - frame_start repeats every 32 cycles.
- digits=16'h1234, dp_mask=4'b0100 → seg per slot: slot0 = 99, slot1 = B0, slot2 = 24 (dp lit), slot3 = F9.
- Change digits from 0x0999 to 0x1000 while idx==1 → the remaining slots of that frame still show 0999; the next frame shows 1000. Never a mixed value.
- blank held high for 5 cycles mid-slot → an=1111 for exactly those cycles (one-cycle lag). idx and frame_start timing are unchanged.
- SEVSEG_LZB_EN with digits=16'h0050 → digit3 suppressed (an bit3 never low), digits 2,1,0 show 0,5,0. Without the macro, digit3 shows C0.
- rst_n pulsed low while idx==2 → an=1111 and seg=FF asynchronously. After release, the first tick lands on idx 0 with frame_start.
